// File: rtl/tt_um_andrewtron3000.sv
// Tiny Tapeout tile: 32-cell circular elementary cellular automaton.
// The rule number arrives on ui_in, and uo_out shows one 8-cell window of the row.
module tt_um_andrewtron3000 #(
    parameter logic [31:0] SEED = 32'h0001_0000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [31:0] cells_q, cells_d;
    logic [7:0]  gen_q, gen_d;
    logic [31:0] step_row;
    logic        run;
    logic        load;
    logic [1:0]  sel;
    logic [4:0]  win_base;
    logic        unused_ok;

    assign run      = uio_in[0];
    assign load     = uio_in[1];
    assign sel      = uio_in[3:2];
    assign win_base = {sel, 3'b000};

    // The higher index is the left neighbour, and the row wraps at both ends.
    // Each new cell reads the live rule bit picked by its 3-cell neighbourhood.
    for (genvar gi = 0; gi < 32; gi++) begin : g_cell
        localparam int LEFT  = (gi + 1) % 32;
        localparam int RIGHT = (gi + 31) % 32;
        logic [2:0] nbr_idx;
        assign nbr_idx      = {cells_q[LEFT], cells_q[gi], cells_q[RIGHT]};
        assign step_row[gi] = ui_in[nbr_idx];
    end

    always_comb begin
        cells_d = cells_q;
        gen_d   = gen_q;
        if (ena) begin
            if (load) begin
                cells_d[win_base +: 8] = ui_in;
            end else if (run) begin
                cells_d = step_row;
                gen_d   = gen_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cells_q <= SEED;
            gen_q   <= 8'd0;
        end else begin
            cells_q <= cells_d;
            gen_q   <= gen_d;
        end
    end

    assign uo_out  = cells_q[win_base +: 8];
    assign uio_out = {gen_q[3:0], 4'b0000};
    assign uio_oe  = 8'hF0;

    assign unused_ok = &{1'b0, uio_in[7:4], gen_q[7:4]};

endmodule

// File: tb/tb_tt_um_andrewtron3000.sv
// Directed bench for the cellular automaton tile, with hand-computed expected rows.
module tb_tt_um_andrewtron3000;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int vectors;
    int miscompares;

    tt_um_andrewtron3000 dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("vec %0d %s observed=%h expected=%h", vectors, tag, obs, exp);
    endtask

    task automatic ctl(input logic run, input logic load, input logic [1:0] sel);
        uio_in = {4'b0000, sel, load, run};
    endtask

    task automatic win(input logic [1:0] sel, input string tag, input logic [7:0] exp);
        uio_in[3:2] = sel;
        #1;
        check(tag, uo_out, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b1;
        ena         = 1'b1;
        ui_in       = 8'h00;
        uio_in      = 8'h00;

        // 1. reset state
        #2 rst_n = 1'b0;
        #10 rst_n = 1'b1;
        #1;
        win(2'd0, "rst_sel0", 8'h00);
        win(2'd1, "rst_sel1", 8'h00);
        win(2'd2, "rst_sel2", 8'h01);
        win(2'd3, "rst_sel3", 8'h00);
        check("rst_uio_out", uio_out, 8'h00);
        check("rst_uio_oe", uio_oe, 8'hF0);

        // 2. rule 90, two steps
        ui_in = 8'h5A;
        ctl(1'b1, 1'b0, 2'd1);
        tick();
        ctl(1'b0, 1'b0, 2'd1);
        win(2'd1, "r90_s1_sel1", 8'h80);
        win(2'd2, "r90_s1_sel2", 8'h02);
        check("r90_s1_gen", uio_out, 8'h10);
        ctl(1'b1, 1'b0, 2'd1);
        tick();
        ctl(1'b0, 1'b0, 2'd1);
        win(2'd1, "r90_s2_sel1", 8'h40);
        win(2'd2, "r90_s2_sel2", 8'h04);
        check("r90_s2_gen", uio_out, 8'h20);

        // 3. wrap-around: bit31 and bit14 set, then shift up and back down
        ui_in = 8'h00;
        ctl(1'b0, 1'b1, 2'd2);
        tick();
        ui_in = 8'h80;
        ctl(1'b0, 1'b1, 2'd3);
        tick();
        ui_in = 8'hAA;
        ctl(1'b1, 1'b0, 2'd0);
        tick();
        ctl(1'b0, 1'b0, 2'd0);
        win(2'd0, "wrap_up_sel0", 8'h01);
        win(2'd3, "wrap_up_sel3", 8'h00);
        win(2'd1, "wrap_up_sel1", 8'h80);
        ui_in = 8'hF0;
        ctl(1'b1, 1'b0, 2'd3);
        tick();
        ctl(1'b0, 1'b0, 2'd3);
        win(2'd3, "wrap_dn_sel3", 8'h80);
        win(2'd0, "wrap_dn_sel0", 8'h00);
        win(2'd1, "wrap_dn_sel1", 8'h40);
        check("wrap_gen", uio_out, 8'h40);

        // 4A. load beats run
        ui_in = 8'h3C;
        ctl(1'b1, 1'b1, 2'd1);
        tick();
        ctl(1'b0, 1'b0, 2'd1);
        win(2'd1, "prio_sel1", 8'h3C);
        win(2'd3, "prio_sel3", 8'h80);
        check("prio_gen", uio_out, 8'h40);

        // 4B. ena low holds everything; outputs ignore ui_in changes
        ena = 1'b0;
        ctl(1'b1, 1'b0, 2'd1);
        for (int i = 0; i < 10; i++) begin
            ui_in = 8'(i * 37 + 5);
            tick();
        end
        #1;
        check("ena_sel1", uo_out, 8'h3C);
        check("ena_gen", uio_out, 8'h40);
        ui_in = 8'hFF;
        #1;
        check("no_comb_path", uo_out, 8'h3C);
        ena = 1'b1;
        ctl(1'b0, 1'b0, 2'd0);

        // 5A. 17 identity steps from reset
        rst_n = 1'b0;
        #3 rst_n = 1'b1;
        ui_in = 8'hCC;
        ctl(1'b1, 1'b0, 2'd2);
        for (int i = 0; i < 17; i++) tick();
        ctl(1'b0, 1'b0, 2'd2);
        win(2'd2, "ident_sel2", 8'h01);
        win(2'd0, "ident_sel0", 8'h00);
        check("ident_gen", uio_out, 8'h10);

        // 5B. rule 0 clears the row
        ui_in = 8'h00;
        ctl(1'b1, 1'b0, 2'd2);
        tick();
        ctl(1'b0, 1'b0, 2'd2);
        win(2'd0, "r0_sel0", 8'h00);
        win(2'd1, "r0_sel1", 8'h00);
        win(2'd2, "r0_sel2", 8'h00);
        win(2'd3, "r0_sel3", 8'h00);
        check("r0_gen", uio_out, 8'h20);

        // 6. asynchronous reset mid-run under rule 30
        ui_in = 8'h1E;
        ctl(1'b1, 1'b0, 2'd2);
        tick();
        tick();
        #1 rst_n = 1'b0;
        #1;
        check("async_sel2", uo_out, 8'h01);
        check("async_gen", uio_out, 8'h00);
        check("async_oe", uio_oe, 8'hF0);
        #1 rst_n = 1'b1;
        tick();
        ctl(1'b0, 1'b0, 2'd2);
        win(2'd2, "r30_sel2", 8'h03);
        win(2'd1, "r30_sel1", 8'h80);
        check("r30_gen", uio_out, 8'h10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
